reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags for the out-of-order core.
- Sits between the dispatcher, which reads operands and renames rd, and the reorder-buffer commit port, which writes retired results.
- Each register holds a value V and a tag Q:
  - Q = ROB id of the youngest in-flight producer.
  - Q = 0 means V is valid.
- A misbranch flush clears every tag.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- REG_POS_WIDTH, 5, register index width.
- ROB_ID_WIDTH, 5, ROB id width; id 0 = "no producer", valid ids 1..16.
- DATA_WIDTH, 32, register value width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global ready; when low, all state holds.
- rs1_from_dispatcher  in  REG_POS_WIDTH  source 1 index.
- rs2_from_dispatcher  in  REG_POS_WIDTH  source 2 index.
- Q1_to_dispatcher  out  ROB_ID_WIDTH  source 1 tag (0 = value valid).
- Q2_to_dispatcher  out  ROB_ID_WIDTH  source 2 tag.
- V1_to_dispatcher  out  DATA_WIDTH  source 1 value.
- V2_to_dispatcher  out  DATA_WIDTH  source 2 value.
- rename_signal_from_dispatcher  in  1  rename request for rd.
- rd_from_dispatcher  in  REG_POS_WIDTH  destination to rename.
- rob_id_from_dispatcher  in  ROB_ID_WIDTH  newly allocated ROB id.
- commit_flag_from_rob  in  1  a commit is presented this cycle.
- rd_from_rob  in  REG_POS_WIDTH  committed destination.
- Q_from_rob  in  ROB_ID_WIDTH  ROB id of the committing entry.
- V_from_rob  in  DATA_WIDTH  committed value.
- misbranch_flag  in  1  flush all rename tags.

Behaviour:
- Reset (rst high at posedge): all V = 0, all Q = 0. Read outputs are combinational, so after reset every read returns Q = 0, V = 0.
- rdy low and rst low: no state change. Reads remain combinational.
- Read path, combinational, independent per port:
  - rs = 0 -> Q = 0, V = 0, always.
  - Otherwise, if commit_flag_from_rob, rd_from_rob = rs (nonzero) and Q_from_rob = Q[rs]: bypass, returning Q = 0 and V = V_from_rob.
  - Otherwise return stored Q[rs], V[rs].
  - The bypass is mandatory. Without it, the dispatcher would capture a tag whose ROB entry is already freed.
- Commit (posedge, rdy, commit_flag_from_rob, rd_from_rob != 0):
  - V[rd] <= V_from_rob, unconditionally.
  - Q[rd] <= 0 only if Q[rd] == Q_from_rob; a younger rename stays in place.
- Rename (posedge, rdy, rename_signal_from_dispatcher, rd_from_dispatcher != 0, misbranch_flag low): Q[rd] <= rob_id_from_dispatcher.
- Rename and commit to the same rd in the same cycle:
  - V is written.
  - Q takes the new rename id; rename has priority over the commit clear.
- Misbranch (posedge, rdy, misbranch_flag):
  - All Q <= 0.
  - A commit in the same cycle still writes V (the branch's own rd, e.g. jal link).
  - A rename in the same cycle is ignored.
- x0: never written, never renamed; Q[0] and V[0] stay 0.
- No other latency: writes are visible on reads in the cycle after the edge.
- Reset mid-operation (rst during pending renames) discards all tags and values; rst has priority over everything.

Optional Feature:
- Macro: REG_FILE_DEBUG_EN.
- Enabled:
  - Adds output debug_commit_count (32 bits).
  - It counts cycles with rdy && commit_flag_from_rob, including commits to x0.
  - Reset to 0; wraps at 2^32.
  - Adds output debug_x10 (DATA_WIDTH), which is V[10].
- Disabled: both ports and the counter are absent; functional behaviour is identical.

Test Plan:
- Reset, then read rs1 = 5, rs2 = 0 -> Q1 = 0, V1 = 0, Q2 = 0, V2 = 0.
- Rename x5 with id 3, next cycle read x5 -> Q1 = 3. Then commit rd = 5, Q = 3, V = 0x1234 with rs1 = 5 in the same cycle -> Q1 = 0, V1 = 0x1234 (bypass). Next cycle stored Q[5] = 0, V[5] = 0x1234.
- Rename x7 with id 2, then rename x7 with id 4, then commit rd = 7, Q = 2, V = 0xAA -> V[7] = 0xAA, Q[7] stays 4; reading x7 returns Q = 4, not bypassed.
- Same cycle: commit rd = 9 with matching Q = 1, V = 0x55, and rename rd = 9 with id 6 -> V[9] = 0x55, Q[9] = 6.
- Rename x1 with id 1, x2 with id 2, x3 with id 3, then misbranch_flag together with commit rd = 1, Q = 1, V = 0x80 and rename rd = 4 with id 5 -> all Q = 0, V[1] = 0x80, Q[4] = 0.
- Commit rd = 0, V = 0xFFFF and rename rd = 0 with id 7 -> reads of x0 give Q = 0, V = 0. With rdy low, a commit to x6 is ignored. With REG_FILE_DEBUG_EN, debug_commit_count increments only for the rdy-high commit.

Source files
------------

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register rename tags.
// Each register holds a value (v) and the ROB id of its youngest in-flight
// producer (q, 0 = value valid). Reads are combinational, and a same-cycle
// commit whose ROB id still matches the stored tag is forwarded to the read.
// Optional debug outputs are enabled with the REG_FILE_DEBUG_EN macro.
module reg_file_rename #(
  parameter int REG_NUM       = 32,
  parameter int REG_POS_WIDTH = 5,
  parameter int ROB_ID_WIDTH  = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [REG_POS_WIDTH-1:0] rs1_from_dispatcher,
  input  logic [REG_POS_WIDTH-1:0] rs2_from_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]  Q1_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]  Q2_to_dispatcher,
  output logic [DATA_WIDTH-1:0]    V1_to_dispatcher,
  output logic [DATA_WIDTH-1:0]    V2_to_dispatcher,
  input  logic                     rename_signal_from_dispatcher,
  input  logic [REG_POS_WIDTH-1:0] rd_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0]  rob_id_from_dispatcher,
  input  logic                     commit_flag_from_rob,
  input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
  input  logic [DATA_WIDTH-1:0]    V_from_rob,
`ifdef REG_FILE_DEBUG_EN
  output logic [31:0]              debug_commit_count,
  output logic [DATA_WIDTH-1:0]    debug_x10,
`endif
  input  logic                     misbranch_flag
);

  logic [DATA_WIDTH-1:0]   v_q [REG_NUM];
  logic [DATA_WIDTH-1:0]   v_d [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] q_q [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] q_d [REG_NUM];

  logic commit_wr;
  logic rename_wr;

  assign commit_wr = rdy && commit_flag_from_rob && (rd_from_rob != '0);
  assign rename_wr = rdy && rename_signal_from_dispatcher &&
                     (rd_from_dispatcher != '0) && !misbranch_flag;

  // Next-state: commit clears a matching tag, rename (applied after) wins on
  // the same rd, and a misbranch wipes every tag while still letting V land.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      v_d[i] = v_q[i];
      q_d[i] = q_q[i];
    end
    if (commit_wr) begin
      v_d[rd_from_rob] = V_from_rob;
      if (q_q[rd_from_rob] == Q_from_rob) begin
        q_d[rd_from_rob] = '0;
      end
    end
    if (rdy && misbranch_flag) begin
      for (int i = 0; i < REG_NUM; i++) begin
        q_d[i] = '0;
      end
    end else if (rename_wr) begin
      q_d[rd_from_dispatcher] = rob_id_from_dispatcher;
    end
  end

  // State registers; x0 is never targeted by the next-state logic, so it
  // stays at its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= v_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

  // Source 1 read with commit forwarding so a freed ROB id is never handed out.
  always_comb begin
    Q1_to_dispatcher = '0;
    V1_to_dispatcher = '0;
    if (rs1_from_dispatcher != '0) begin
      if (commit_flag_from_rob && (rd_from_rob == rs1_from_dispatcher) &&
          (Q_from_rob == q_q[rs1_from_dispatcher])) begin
        V1_to_dispatcher = V_from_rob;
      end else begin
        Q1_to_dispatcher = q_q[rs1_from_dispatcher];
        V1_to_dispatcher = v_q[rs1_from_dispatcher];
      end
    end
  end

  // Source 2 read, same forwarding rule as source 1.
  always_comb begin
    Q2_to_dispatcher = '0;
    V2_to_dispatcher = '0;
    if (rs2_from_dispatcher != '0) begin
      if (commit_flag_from_rob && (rd_from_rob == rs2_from_dispatcher) &&
          (Q_from_rob == q_q[rs2_from_dispatcher])) begin
        V2_to_dispatcher = V_from_rob;
      end else begin
        Q2_to_dispatcher = q_q[rs2_from_dispatcher];
        V2_to_dispatcher = v_q[rs2_from_dispatcher];
      end
    end
  end

`ifdef REG_FILE_DEBUG_EN
  logic [31:0] commit_count_q;
  logic [31:0] commit_count_d;

  // Counts every accepted commit cycle, x0 included; wraps naturally.
  always_comb begin
    commit_count_d = commit_count_q;
    if (rdy && commit_flag_from_rob) begin
      commit_count_d = commit_count_q + 32'd1;
    end
  end

  // Debug counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count_q <= '0;
    end else begin
      commit_count_q <= commit_count_d;
    end
  end

  assign debug_commit_count = commit_count_q;
  assign debug_x10          = v_q[10];
`endif

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed, table-driven bench for reg_file_rename, plus hand-written
// sequences for x10 visibility and reset in the middle of activity.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  rs1, rs2;
  logic [4:0]  q1, q2;
  logic [31:0] v1, v2;
  logic        ren;
  logic [4:0]  rd_d;
  logic [4:0]  rob_id;
  logic        cmt;
  logic [4:0]  rd_r;
  logic [4:0]  q_r;
  logic [31:0] v_r;
  logic        mis;
`ifdef REG_FILE_DEBUG_EN
  logic [31:0] dbg_cnt;
  logic [31:0] dbg_x10;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk                           (clk),
    .rst                           (rst),
    .rdy                           (rdy),
    .rs1_from_dispatcher           (rs1),
    .rs2_from_dispatcher           (rs2),
    .Q1_to_dispatcher              (q1),
    .Q2_to_dispatcher              (q2),
    .V1_to_dispatcher              (v1),
    .V2_to_dispatcher              (v2),
    .rename_signal_from_dispatcher (ren),
    .rd_from_dispatcher            (rd_d),
    .rob_id_from_dispatcher        (rob_id),
    .commit_flag_from_rob          (cmt),
    .rd_from_rob                   (rd_r),
    .Q_from_rob                    (q_r),
    .V_from_rob                    (v_r),
`ifdef REG_FILE_DEBUG_EN
    .debug_commit_count            (dbg_cnt),
    .debug_x10                     (dbg_x10),
`endif
    .misbranch_flag                (mis)
  );

  typedef struct {
    logic        rdy;
    logic        ren;
    logic [4:0]  rd_d;
    logic [4:0]  rob_id;
    logic        cmt;
    logic [4:0]  rd_r;
    logic [4:0]  q_r;
    logic [31:0] v_r;
    logic        mis;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  eq1;
    logic [31:0] ev1;
    logic [4:0]  eq2;
    logic [31:0] ev2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy    = v.rdy;
    ren    = v.ren;
    rd_d   = v.rd_d;
    rob_id = v.rob_id;
    cmt    = v.cmt;
    rd_r   = v.rd_r;
    q_r    = v.q_r;
    v_r    = v.v_r;
    mis    = v.mis;
    rs1    = v.rs1;
    rs2    = v.rs2;
  endtask

  task automatic idle();
    rdy = 1'b1; ren = 1'b0; rd_d = '0; rob_id = '0; cmt = 1'b0;
    rd_r = '0; q_r = '0; v_r = '0; mis = 1'b0; rs1 = '0; rs2 = '0;
  endtask

  // Reads are checked before the edge on which the vector's writes land.
  task automatic check_reads(input string tag, input logic [4:0] eq1, input logic [31:0] ev1,
                             input logic [4:0] eq2, input logic [31:0] ev2);
    #1;
    chk({tag, " Q1"}, {27'd0, q1}, {27'd0, eq1});
    chk({tag, " V1"}, v1, ev1);
    chk({tag, " Q2"}, {27'd0, q2}, {27'd0, eq2});
    chk({tag, " V2"}, v2, ev2);
  endtask

  initial begin
    // Field order: rdy ren rd_d rob_id cmt rd_r q_r v_r mis rs1 rs2 | eq1 ev1 eq2 ev2
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 5, 3, 0, 0, 0, 32'h0,        0, 5, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0,  3, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 5, 3, 32'h1234,     0, 5, 5,  0, 32'h1234,     0, 32'h1234});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0,  0, 32'h1234,     0, 32'h0});
    vecs.push_back('{1, 1, 7, 2, 0, 0, 0, 32'h0,        0, 7, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 7, 4, 0, 0, 0, 32'h0,        0, 7, 0,  2, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 7, 2, 32'hAA,       0, 7, 0,  4, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 5,  4, 32'hAA,       0, 32'h1234});
    vecs.push_back('{1, 1, 9, 1, 0, 0, 0, 32'h0,        0, 9, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 9, 6, 1, 9, 1, 32'h55,       0, 9, 0,  0, 32'h55,       0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 9, 0,  6, 32'h55,       0, 32'h0});
    vecs.push_back('{1, 1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 2, 2, 0, 0, 0, 32'h0,        0, 1, 0,  1, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 3, 3, 0, 0, 0, 32'h0,        0, 2, 1,  2, 32'h0,        1, 32'h0});
    vecs.push_back('{1, 1, 4, 5, 1, 1, 1, 32'h80,       1, 3, 1,  3, 32'h0,        0, 32'h80});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 4,  0, 32'h80,       0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2, 3,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 9,  0, 32'hAA,       0, 32'h55});
    vecs.push_back('{1, 1, 0, 7, 1, 0, 0, 32'hFFFF,     0, 0, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 1, 31, 16, 0, 0, 0, 32'h0,      0, 31, 0, 0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 31, 0, 16, 32'h0,       0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 1, 31, 16, 32'hDEADBEEF, 0, 31, 0, 0, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 31, 0, 0, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{0, 1, 5, 9, 1, 6, 0, 32'h66,       0, 5, 7,  0, 32'h1234,     0, 32'hAA});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6, 5,  0, 32'h0,        0, 32'h1234});

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check_reads($sformatf("vec%0d", i), vecs[i].eq1, vecs[i].ev1, vecs[i].eq2, vecs[i].ev2);
      @(negedge clk);
    end

`ifdef REG_FILE_DEBUG_EN
    #1;
    chk("commit_count", dbg_cnt, 32'd6);
`endif

    // Commit to x10 alongside a rename of x12, then confirm both stick.
    idle();
    cmt = 1'b1; rd_r = 5'd10; q_r = 5'd0; v_r = 32'hA5A5;
    ren = 1'b1; rd_d = 5'd12; rob_id = 5'd7;
    @(negedge clk);
    idle();
    rs1 = 5'd10; rs2 = 5'd12;
    check_reads("x10_x12", 5'd0, 32'hA5A5, 5'd7, 32'h0);
`ifdef REG_FILE_DEBUG_EN
    chk("debug_x10", dbg_x10, 32'hA5A5);
    chk("commit_count2", dbg_cnt, 32'd7);
`endif

    // Reset with a rename and commit pending must discard everything.
    @(negedge clk);
    rst = 1'b1;
    ren = 1'b1; rd_d = 5'd13; rob_id = 5'd9;
    cmt = 1'b1; rd_r = 5'd14; q_r = 5'd0; v_r = 32'h1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    rs1 = 5'd10; rs2 = 5'd12;
    check_reads("rst_mid_a", 5'd0, 32'h0, 5'd0, 32'h0);
    rs1 = 5'd13; rs2 = 5'd14;
    check_reads("rst_mid_b", 5'd0, 32'h0, 5'd0, 32'h0);
    rs1 = 5'd5; rs2 = 5'd31;
    check_reads("rst_mid_c", 5'd0, 32'h0, 5'd0, 32'h0);
`ifdef REG_FILE_DEBUG_EN
    chk("commit_count_rst", dbg_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
